// File: rtl/approx_mul_pkg.sv
// Shared types and constants for the iterative tile multiplier.
// APPROX_MUL_EXACT_EN selects an exact 16-bit tile instead of the 15-bit saturating one.
package approx_mul_pkg;

  localparam int TILE_W = 8;
`ifdef APPROX_MUL_EXACT_EN
  localparam int TILE_P_W = 16;
`else
  localparam int TILE_P_W = 15;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Reference tile behaviour; the approximate form clamps to the largest 15-bit value.
  function automatic logic [TILE_P_W-1:0] tile_ref(input logic [TILE_W-1:0] x,
                                                   input logic [TILE_W-1:0] y);
    logic [2*TILE_W-1:0] full;
    full = x * y;
`ifdef APPROX_MUL_EXACT_EN
    return full;
`else
    return (full > 16'h7FFF) ? 15'h7FFF : full[14:0];
`endif
  endfunction

endpackage

// File: rtl/approx_tile_8x8.sv
// Combinational 8x8 tile multiplier; exact when APPROX_MUL_EXACT_EN is defined,
// otherwise a 15-bit saturating approximation that never exceeds the exact product.
module approx_tile_8x8
  import approx_mul_pkg::*;
(
  input  logic [TILE_W-1:0]   x,
  input  logic [TILE_W-1:0]   y,
  output logic [TILE_P_W-1:0] p
);

  logic [2*TILE_W-1:0] full;

  always_comb begin
    full = x * y;
`ifdef APPROX_MUL_EXACT_EN
    p = full;
`else
    p = (full > 16'h7FFF) ? 15'h7FFF : full[14:0];
`endif
  end

endmodule

// File: rtl/approx_mul_iter.sv
// Iterative WIDTHxWIDTH unsigned multiplier: one 8x8 tile per cycle into a 2*WIDTH+1 accumulator.
// Tile accuracy is chosen by APPROX_MUL_EXACT_EN (see approx_tile_8x8).
module approx_mul_iter
  import approx_mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod
);

  localparam int NT = WIDTH / TILE_W;
  localparam int CW = $clog2(NT);
  localparam int AW = 2 * WIDTH + 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      i_q, i_d, j_q, j_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [TILE_W-1:0]   tile_x, tile_y;
  logic [TILE_P_W-1:0] tile_p;
  logic [CW:0]         ij_sum;
  logic [AW-1:0]       tile_sh;

  assign tile_x = a_q[TILE_W*j_q +: TILE_W];
  assign tile_y = b_q[TILE_W*i_q +: TILE_W];

  approx_tile_8x8 u_tile (
    .x (tile_x),
    .y (tile_y),
    .p (tile_p)
  );

  // Tile weight is 2^(8*(i+j)); the extra counter bit keeps i+j from wrapping.
  assign ij_sum  = {1'b0, i_q} + {1'b0, j_q};
  assign tile_sh = AW'(tile_p) << {ij_sum, 3'b000};

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_q + tile_sh;
        if (j_q == CW'(NT - 1)) begin
          j_d = '0;
          if (i_q == CW'(NT - 1)) begin
            prod_d  = acc_d[2*WIDTH-1:0];
            state_d = DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign prod      = prod_q;

endmodule

// File: tb/tb_approx_mul_iter.sv
// Bench for approx_mul_iter at WIDTH=16 and WIDTH=32; expectations follow APPROX_MUL_EXACT_EN.
// Latency is counted with the accepting edge as edge 1.
module tb_approx_mul_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a16, b16;
  logic [31:0] prod16;
  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] a32, b32;
  logic [63:0] prod32;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  approx_mul_iter #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a16), .b(b16), .out_valid(out_valid), .out_ready(out_ready), .prod(prod16)
  );

  approx_mul_iter #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .out_valid(out_valid32), .out_ready(out_ready32), .prod(prod32)
  );

  // Product from the tile rules: sum of clamped byte products at byte weights, truncated to 2w bits.
  function automatic logic [127:0] model(input logic [63:0] x, input logic [63:0] y, input int w);
    logic [127:0]    s;
    longint unsigned p;
    s = '0;
    p = 0;
`ifdef APPROX_MUL_EXACT_EN
    s = 128'(x) * 128'(y);
`else
    for (int i = 0; i < w / 8; i++)
      for (int j = 0; j < w / 8; j++) begin
        p = longint'({56'b0, x[8*j +: 8]}) * longint'({56'b0, y[8*i +: 8]});
        if (p > 32767) p = 32767;
        s = s + (128'(p) << (8 * (i + j)));
      end
`endif
    s = s & ((128'(1) << (2 * w)) - 128'(1));
    return s;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=16 transaction; with hold set, the result is held 10 cycles under in_valid noise.
  task automatic do16(input logic [15:0] av, input logic [15:0] bv, input logic [31:0] ev,
                      input string tag, input bit hold);
    int lat;
    bit got;
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1; a16 = av; b16 = bv;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (out_valid) got = 1'b1;
      else begin
        chk({tag, "_in_ready_busy"}, in_ready, 0);
        in_valid = 1'($urandom);
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    chk({tag, "_timeout"}, got, 1);
    chk({tag, "_latency"}, lat, 5);
    chk({tag, "_prod"}, prod16, ev);
    chk({tag, "_in_ready_done"}, in_ready, 0);
    if (hold) begin
      for (int k = 0; k < 10; k++) begin
        in_valid = 1'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_hold_valid"}, out_valid, 1);
        chk({tag, "_hold_prod"}, prod16, ev);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_release_valid"}, out_valid, 0);
    chk({tag, "_release_ready"}, in_ready, 1);
  endtask

  task automatic do32(input logic [31:0] av, input logic [31:0] bv);
    int lat;
    bit got;
    while (!in_ready32) @(negedge clk);
    in_valid32 = 1'b1; a32 = av; b32 = bv;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid32 = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      if (out_valid32) got = 1'b1;
      else begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
    end
    chk("w32_latency", lat, 17);
    chk("w32_prod", prod32, model({32'b0, av}, {32'b0, bv}, 32));
  endtask

  initial begin
    logic [31:0] ffff_exp;
    logic [15:0] ra, rb;
    int done32;
`ifdef APPROX_MUL_EXACT_EN
    ffff_exp = 32'hFFFE0001;
`else
    ffff_exp = 32'h80FF7DFF;
`endif
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a16 = '0; b16 = '0;
    in_valid32 = 1'b0; out_ready32 = 1'b1; a32 = '0; b32 = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_prod", prod16, 0);
    chk("rst_prod32", prod32, 0);
    rst_n = 1'b1;

    do16(16'h0012, 16'h0034, 32'h000003A8, "small", 1'b0);
    do16(16'hFFFF, 16'hFFFF, ffff_exp, "ffff", 1'b0);
    do16(16'h1234, 16'h0000, 32'h0, "b_zero", 1'b0);
    do16(16'hABCD, 16'h0F0F, 32'(model(64'hABCD, 64'h0F0F, 16)), "stall", 1'b1);

    // Abort during the third BUSY tile.
    @(negedge clk);
    in_valid = 1'b1; a16 = 16'hBEEF; b16 = 16'hCAFE;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_prod", prod16, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do16(16'd3, 16'd5, 32'd15, "after_abort", 1'b0);

    for (int n = 0; n < 20; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      do16(ra, rb, 32'(model({48'b0, ra}, {48'b0, rb}, 16)), "rand16", 1'b0);
    end

    done32 = 0;
    for (int n = 0; n < 200; n++) begin
      do32($urandom, $urandom);
      done32++;
    end
    chk("w32_count", done32, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
